// File: rtl/car_sequencer_pkg.sv
// Shared micro-address encodings, operand classes and opcode constants for the CAR sequencer.
// Used by car_sequencer and car_mode_decode; build option MSP_LPM_EN lives in the top module.
package car_sequencer_pkg;

    // Sequences are laid out contiguously so every non-final state steps to encoding + 1.
    typedef enum logic [5:0] {
        Car0,
        CarRegReg,
        CarRegIdx0, CarRegIdx1, CarRegIdx2, CarRegIdx3,
        CarIndReg0, CarIndReg1,
        CarIndIdx0, CarIndIdx1, CarIndIdx2, CarIndIdx3, CarIndIdx4,
        CarIdxReg0, CarIdxReg1, CarIdxReg2,
        CarIdxIdx0, CarIdxIdx1, CarIdxIdx2, CarIdxIdx3, CarIdxIdx4, CarIdxIdx5,
        Car1opReg,
        Car1opInd0, Car1opInd1, Car1opInd2,
        Car1opIdx0, Car1opIdx1, Car1opIdx2, Car1opIdx3,
        CarPushReg0, CarPushReg1, CarPushReg2,
        CarPushInd0, CarPushInd1, CarPushInd2,
        CarPushIdx0, CarPushIdx1, CarPushIdx2, CarPushIdx3,
        CarCallReg0, CarCallReg1, CarCallReg2,
        CarCallInd0, CarCallInd1, CarCallInd2,
        CarCallIdx0, CarCallIdx1, CarCallIdx2, CarCallIdx3,
        CarReti0, CarReti1, CarReti2, CarReti3,
        CarInt0, CarInt1, CarInt2, CarInt3, CarInt4,
        CarJmp0,
        CarLpm
    } car_e;

    typedef enum logic [1:0] {ClsReg, ClsInd, ClsIdx} src_cls_e;

    localparam logic [2:0] OpPush = 3'b100;
    localparam logic [2:0] OpCall = 3'b101;
    localparam logic [2:0] OpReti = 3'b110;
    localparam logic [2:0] OpIll  = 3'b111;

    localparam logic [3:0] RegPc = 4'd0;
    localparam logic [3:0] RegSp = 4'd1;
    localparam logic [3:0] RegSr = 4'd2;
    localparam logic [3:0] RegCg = 4'd3;

    function automatic logic is_seq_last(input car_e s);
        return s inside {CarRegReg, CarRegIdx3, CarIndReg1, CarIndIdx4, CarIdxReg2, CarIdxIdx5,
                         Car1opReg, Car1opInd2, Car1opIdx3, CarPushReg2, CarPushInd2,
                         CarPushIdx3, CarCallReg2, CarCallInd2, CarCallIdx3, CarReti3,
                         CarInt4, CarJmp0};
    endfunction

    function automatic car_e pick_by_cls(input src_cls_e cls, input car_e reg_s,
                                         input car_e ind_s, input car_e idx_s);
        case (cls)
            ClsInd:  return ind_s;
            ClsIdx:  return idx_s;
            default: return reg_s;
        endcase
    endfunction

endpackage

// File: rtl/car_mode_decode.sv
// Combinational instruction classifier: format, legality and operand addressing class.
module car_mode_decode
    import car_sequencer_pkg::*;
(
    input  logic [15:0] ir_i,
    output logic        fmt1_o,
    output logic        fmt2_o,
    output logic        jump_o,
    output logic        illegal_o,
    output src_cls_e    src_cls_o,
    output logic        dst_idx_o
);

    logic [3:0] src_reg;
    logic [1:0] as_bits;
    logic       unused_bw;

    assign unused_bw = ir_i[6];

    always_comb begin
        as_bits   = ir_i[5:4];
        jump_o    = (ir_i[15:13] == 3'b001);
        fmt2_o    = (ir_i[15:10] == 6'b000100);
        fmt1_o    = (ir_i[15:14] != 2'b00);
        illegal_o = !(jump_o || fmt1_o || fmt2_o) || (fmt2_o && (ir_i[9:7] == OpIll));
        dst_idx_o = ir_i[7];
        src_reg   = fmt2_o ? ir_i[3:0] : ir_i[11:8];
        // Constant generator registers need no memory access; absolute (R2,As=01) still does.
        if (src_reg == RegCg || (src_reg == RegSr && as_bits[1])) begin
            src_cls_o = ClsReg;
        end else if (as_bits[1]) begin
            src_cls_o = ClsInd;
        end else if (as_bits[0]) begin
            src_cls_o = ClsIdx;
        end else begin
            src_cls_o = ClsReg;
        end
    end

endmodule

// File: rtl/car_sequencer.sv
// Microsequencer generating the control address register (CAR) for the CPU control unit.
// Define MSP_LPM_EN to enable the low-power hold state CarLpm (entered on CPUOFF at a boundary).
module car_sequencer
    import car_sequencer_pkg::*;
#(
    parameter int unsigned CAR_BITS = 6
) (
    input  logic                MCLK,
    input  logic                reset,
    input  logic [15:0]         IR,
    input  logic                MEM_RDY,
    input  logic                INTREQ,
    input  logic                NMI,
    input  logic                GIE,
    input  logic                CPUOFF,
    output logic [CAR_BITS-1:0] CAR,
    output logic                BOUNDARY
);

    car_e     car_q, car_d;
    logic     fmt1, fmt2, jump, illegal, dst_idx, int_take;
    src_cls_e src_cls;

    car_mode_decode u_decode (
        .ir_i      (IR),
        .fmt1_o    (fmt1),
        .fmt2_o    (fmt2),
        .jump_o    (jump),
        .illegal_o (illegal),
        .src_cls_o (src_cls),
        .dst_idx_o (dst_idx)
    );

`ifndef MSP_LPM_EN
    logic unused_cpuoff;
    assign unused_cpuoff = CPUOFF;
`endif

    assign int_take = INTREQ & (GIE | NMI);

    always_comb begin
        car_d = car_q;
        case (car_q)
            Car0: begin
                if (int_take) begin
                    car_d = CarInt0;
`ifdef MSP_LPM_EN
                end else if (CPUOFF) begin
                    car_d = CarLpm;
`endif
                end else if (illegal) begin
                    car_d = Car0;
                end else if (jump) begin
                    car_d = CarJmp0;
                end else if (fmt2) begin
                    case (IR[9:7])
                        OpPush:  car_d = pick_by_cls(src_cls, CarPushReg0, CarPushInd0, CarPushIdx0);
                        OpCall:  car_d = pick_by_cls(src_cls, CarCallReg0, CarCallInd0, CarCallIdx0);
                        OpReti:  car_d = CarReti0;
                        default: car_d = pick_by_cls(src_cls, Car1opReg, Car1opInd0, Car1opIdx0);
                    endcase
                end else if (fmt1) begin
                    car_d = dst_idx ? pick_by_cls(src_cls, CarRegIdx0, CarIndIdx0, CarIdxIdx0)
                                    : pick_by_cls(src_cls, CarRegReg, CarIndReg0, CarIdxReg0);
                end
            end
`ifdef MSP_LPM_EN
            CarLpm: begin
                if (int_take) begin
                    car_d = CarInt0;
                end
            end
`endif
            default: begin
                // Encodings above CarJmp0 are unused here and recover to the boundary.
                if (car_q > CarJmp0 || is_seq_last(car_q)) begin
                    car_d = Car0;
                end else begin
                    car_d = car_e'(car_q + 6'd1);
                end
            end
        endcase
        if (!MEM_RDY) begin
            car_d = car_q;
        end
    end

    always_ff @(posedge MCLK) begin
        if (reset) begin
            car_q <= Car0;
        end else begin
            car_q <= car_d;
        end
    end

    assign CAR = CAR_BITS'(car_q);
`ifdef MSP_LPM_EN
    assign BOUNDARY = (car_q == Car0) || (car_q == CarLpm);
`else
    assign BOUNDARY = (car_q == Car0);
`endif

endmodule

// File: tb/tb_car_sequencer.sv
// Scoreboard bench for car_sequencer: stimulus queues expected CAR/BOUNDARY per cycle, a monitor
// compares at the falling edge.
`timescale 1ns/1ps
module tb_car_sequencer;
    import car_sequencer_pkg::*;

    logic        MCLK = 1'b0;
    logic        reset, MEM_RDY, INTREQ, NMI, GIE, CPUOFF;
    logic [15:0] IR;
    logic [5:0]  CAR;
    logic        BOUNDARY;

    car_sequencer #(.CAR_BITS(6)) dut (
        .MCLK     (MCLK),
        .reset    (reset),
        .IR       (IR),
        .MEM_RDY  (MEM_RDY),
        .INTREQ   (INTREQ),
        .NMI      (NMI),
        .GIE      (GIE),
        .CPUOFF   (CPUOFF),
        .CAR      (CAR),
        .BOUNDARY (BOUNDARY)
    );

    always #5 MCLK = ~MCLK;

    typedef struct {
        int unsigned cyc;
        logic [5:0]  car;
        logic        bnd;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge MCLK) cyc <= cyc + 1;

    always @(negedge MCLK) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (CAR !== e.car || BOUNDARY !== e.bnd) begin
                errors++;
                $display("FAIL %s: CAR=%0d BOUNDARY=%0b, expected CAR=%0d BOUNDARY=%0b",
                         e.name, CAR, BOUNDARY, e.car, e.bnd);
            end
        end
    end

    task automatic step(input car_e exp_car, input string name);
        exp_t e;
        e.cyc  = cyc + 1;
        e.car  = exp_car;
        e.bnd  = (exp_car == Car0) || (exp_car == CarLpm);
        e.name = name;
        sb.push_back(e);
        @(posedge MCLK);
        #1;
    endtask

    // Dispatch from Car0, walk first..last, then expect the return to Car0.
    task automatic run_seq(input car_e first, input car_e last, input string name);
        for (int i = int'(first); i <= int'(last); i++) step(car_e'(6'(i)), name);
        step(Car0, name);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000 ns, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; IR = 16'h0000; MEM_RDY = 1'b1;
        INTREQ = 1'b0; NMI = 1'b0; GIE = 1'b0; CPUOFF = 1'b0;
        step(Car0, "reset");
        step(Car0, "reset_hold");
        reset = 1'b0;

        IR = 16'h4405; run_seq(CarRegReg, CarRegReg, "mov_reg_reg");
        IR = 16'h54B5; run_seq(CarIndIdx0, CarIndIdx4, "add_ind_idx");

        IR = 16'h54B5;
        step(CarIndIdx0, "stall_seq"); step(CarIndIdx1, "stall_seq"); step(CarIndIdx2, "stall_seq");
        MEM_RDY = 1'b0;
        step(CarIndIdx2, "stall_hold"); step(CarIndIdx2, "stall_hold");
        MEM_RDY = 1'b1;
        step(CarIndIdx3, "stall_seq"); step(CarIndIdx4, "stall_seq"); step(Car0, "stall_seq");

        IR = 16'h1205; run_seq(CarPushReg0, CarPushReg2, "push_reg");
        IR = 16'h1300; run_seq(CarReti0, CarReti3, "reti");
        IR = 16'h4335; run_seq(CarRegReg, CarRegReg, "cg_r3");
        IR = 16'h4225; run_seq(CarRegReg, CarRegReg, "cg_r2_as10");
        IR = 16'h4215; run_seq(CarIdxReg0, CarIdxReg2, "absolute");
        IR = 16'h4035; run_seq(CarIndReg0, CarIndReg1, "immediate");
        IR = 16'h3C00; run_seq(CarJmp0, CarJmp0, "jump");
        IR = 16'h1015; run_seq(Car1opIdx0, Car1opIdx3, "rrc_idx");
        IR = 16'h12A5; run_seq(CarCallInd0, CarCallInd2, "call_ind");
        IR = 16'h1380; step(Car0, "fmt2_illegal");
        IR = 16'h0000; step(Car0, "illegal_nop");

        IR = 16'h4405; MEM_RDY = 1'b0;
        step(Car0, "stall_in_car0");
        MEM_RDY = 1'b1;
        run_seq(CarRegReg, CarRegReg, "deferred_dispatch");

        IR = 16'h4495;
        step(CarIdxIdx0, "idx_idx"); step(CarIdxIdx1, "idx_idx"); step(CarIdxIdx2, "idx_idx");
        reset = 1'b1; IR = 16'h0000;
        step(Car0, "reset_mid_seq");
        reset = 1'b0;

        IR = 16'h4485;
        step(CarRegIdx0, "reg_idx"); step(CarRegIdx1, "reg_idx");
        INTREQ = 1'b1; GIE = 1'b1;
        step(CarRegIdx2, "int_wait"); step(CarRegIdx3, "int_wait"); step(Car0, "int_wait");
        step(CarInt0, "int_entry");
        INTREQ = 1'b0; IR = 16'h0000;
        step(CarInt1, "int_seq"); step(CarInt2, "int_seq"); step(CarInt3, "int_seq");
        step(CarInt4, "int_seq"); step(Car0, "int_seq"); step(Car0, "int_done_nop");

        INTREQ = 1'b1; GIE = 1'b0; NMI = 1'b0; IR = 16'h4405;
        run_seq(CarRegReg, CarRegReg, "masked_int");
        NMI = 1'b1;
        step(CarInt0, "nmi_entry");
        INTREQ = 1'b0; NMI = 1'b0; IR = 16'h0000;
        step(CarInt1, "nmi_seq"); step(CarInt2, "nmi_seq"); step(CarInt3, "nmi_seq");
        step(CarInt4, "nmi_seq"); step(Car0, "nmi_seq");

`ifdef MSP_LPM_EN
        CPUOFF = 1'b1;
        step(CarLpm, "lpm_entry");
        for (int i = 0; i < 10; i++) step(CarLpm, "lpm_hold");
        INTREQ = 1'b1; GIE = 1'b1;
        step(CarInt0, "lpm_wake");
        INTREQ = 1'b0; CPUOFF = 1'b0;
        step(CarInt1, "lpm_int"); step(CarInt2, "lpm_int"); step(CarInt3, "lpm_int");
        step(CarInt4, "lpm_int"); step(Car0, "lpm_int");
`else
        CPUOFF = 1'b1; IR = 16'h4405;
        run_seq(CarRegReg, CarRegReg, "cpuoff_ignored");
        CPUOFF = 1'b0;
`endif

        repeat (3) @(posedge MCLK);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
